// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore sequencer for a shared multicycle MIPS datapath (one ALU, one
//   unified memory, IR / A / B / ALUOut registers). Each instruction is
//   stepped through FETCH / DECODE / EXEC / MEM / WB. Memory accesses
//   stall on mem_ready.
//
// Ports
//   clk, reset          system clock; synchronous active-high reset
//   op, funct           IR[31:26] and IR[5:0]
//   zero                ALU zero flag (current cycle)
//   mem_ready           unified memory completes its access this cycle
//   pcen, memwrite,     PC enable, memory write strobe,
//   irwrite, regwrite   IR load enable, register file write enable
//   iord                memory address select (0 PC, 1 ALUOut)
//   memtoreg, regdst    write-back data / destination register selects
//   alusrca, alusrcb    ALU operand selects
//   pcsrc               next-PC select (00 ALU, 01 ALUOut, 10 jump)
//   signOrZero          immediate extension (1 = zero-extend)
//   alucontrol          ALU operation
//   illegal_op          one-cycle pulse in DECODE for an unsupported opcode
//   state               current state, exported for debug
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       signOrZero,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        WBIMM   = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12,
        ORIEX   = 4'd13
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     cur;
    state_t     dec;
    logic [1:0] aluop;

    assign state = cur;

    // State register and next-state logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:   if (mem_ready) cur <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_RTYP:      cur <= RTYPEEX;
                        OP_BEQ:       cur <= BEQEX;
                        OP_BNE:       cur <= BNEEX;
                        OP_ADDI:      cur <= ADDIEX;
                        OP_ORI:       cur <= ORIEX;
                        OP_J:         cur <= JEX;
                        default:      cur <= FETCH;
                    endcase
                end
                MEMADR:  cur <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   if (mem_ready) cur <= MEMWB;
                MEMWR:   if (mem_ready) cur <= FETCH;
                RTYPEEX: cur <= RTYPEWB;
                ADDIEX:  cur <= WBIMM;
                ORIEX:   cur <= WBIMM;
                default: cur <= FETCH;
            endcase
        end
    end

    // Output decode. While reset is held the datapath sees FETCH controls,
    // but every strobe that changes architectural state is suppressed so an
    // aborted instruction leaves no trace.
    always_comb begin
        dec        = reset ? FETCH : cur;
        pcen       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        signOrZero = 1'b0;
        aluop      = 2'b00;
        illegal_op = 1'b0;
        case (dec)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_BNE,
                    OP_ADDI, OP_ORI, OP_J: illegal_op = 1'b0;
                    default:               illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX, BNEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                pcen    = (dec == BEQEX) ? zero : ~zero;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                aluop      = 2'b11;
                signOrZero = 1'b1;
            end
            WBIMM: regwrite = 1'b1;
            JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pcen       = 1'b0;
            irwrite    = 1'b0;
            illegal_op = 1'b0;
        end
    end

    // ALU control; unknown R-type funct codes fall back to AND rather than trap.
    always_comb begin
        case (aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            2'b11: alucontrol = 3'b001;
            default: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b000;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus process drives one
// cycle of inputs per falling edge and queues the outputs expected for that
// cycle; an independent monitor samples the DUT shortly after each falling
// edge and checks against the queue head.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       signOrZero, illegal_op;
    logic [2:0] alucontrol;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .iord(iord),
        .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .signOrZero(signOrZero),
        .alucontrol(alucontrol), .illegal_op(illegal_op), .state(state)
    );

    typedef struct packed {
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       soz;
        logic [2:0] aluc;
        logic       ill;
    } outs_t;

    typedef struct {
        int         idx;
        logic [3:0] st;
        outs_t      o;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ncyc = 0;
    bit   done = 1'b0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                           ORI = 6'b001101, J = 6'b000010, BAD = 6'b111111;

    // Hand-tabulated state-only controls; strobes driven by inputs and the
    // ALU code are supplied per cycle by the stimulus.
    function automatic outs_t moore(input logic [3:0] s);
        outs_t o;
        o = '0;
        case (s)
            4'd0:  o.alusrcb = 2'b01;
            4'd1:  o.alusrcb = 2'b11;
            4'd2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
            4'd3:  o.iord = 1;
            4'd4:  begin o.regwrite = 1; o.memtoreg = 1; end
            4'd5:  begin o.memwrite = 1; o.iord = 1; end
            4'd6:  o.alusrca = 1;
            4'd7:  begin o.regwrite = 1; o.regdst = 1; end
            4'd8:  begin o.alusrca = 1; o.pcsrc = 2'b01; end
            4'd9:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
            4'd10: o.regwrite = 1;
            4'd11: o.pcsrc = 2'b10;
            4'd12: begin o.alusrca = 1; o.pcsrc = 2'b01; end
            4'd13: begin o.alusrca = 1; o.alusrcb = 2'b10; o.soz = 1; end
            default: ;
        endcase
        return o;
    endfunction

    // One stimulus cycle: r/o/f/z/mr are the inputs, st the state expected
    // during this cycle, then pcen, irwrite, alucontrol, illegal_op expected.
    task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic mr, input logic [3:0] st,
                       input logic e_pcen, input logic e_irw,
                       input logic [2:0] e_aluc, input logic e_ill);
        exp_t e;
        @(negedge clk);
        reset = r; op = o; funct = f; zero = z; mem_ready = mr;
        e.idx = ncyc;
        e.st  = st;
        e.o   = moore(r ? 4'd0 : st);
        e.o.pcen = e_pcen;
        e.o.irwrite = e_irw;
        e.o.aluc = e_aluc;
        e.o.ill = e_ill;
        q.push_back(e);
        ncyc++;
    endtask

    // Monitor
    initial begin
        exp_t  e;
        outs_t a;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
                      alusrca, alusrcb, pcsrc, signOrZero, alucontrol, illegal_op};
                checks++;
                if (state !== e.st) begin
                    errors++;
                    $display("FAIL state cyc%0d: got %0d want %0d", e.idx, state, e.st);
                end
                checks++;
                if (a !== e.o) begin
                    errors++;
                    $display("FAIL outputs cyc%0d (st %0d): got %b want %b", e.idx, e.st, a, e.o);
                end
            end
        end
    end

    localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, OR = 3'b001;

    initial begin
        // Reset for two cycles with mem_ready high: strobes held off.
        cyc(1, 0, 0, 0, 1, 0, 0, 0, ADD, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, ADD, 0);
        // lw with two memory wait cycles: 0,1,2,3,3,3,4
        cyc(0, LW, 0, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, LW, 0, 0, 1, 1, 0, 0, ADD, 0);
        cyc(0, LW, 0, 0, 1, 2, 0, 0, ADD, 0);
        cyc(0, LW, 0, 0, 0, 3, 0, 0, ADD, 0);
        cyc(0, LW, 0, 0, 0, 3, 0, 0, ADD, 0);
        cyc(0, LW, 0, 0, 1, 3, 0, 0, ADD, 0);
        cyc(0, LW, 0, 0, 1, 4, 0, 0, ADD, 0);
        // sw with one wait in MEMWR: memwrite for two cycles
        cyc(0, SW, 0, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, SW, 0, 0, 1, 1, 0, 0, ADD, 0);
        cyc(0, SW, 0, 0, 1, 2, 0, 0, ADD, 0);
        cyc(0, SW, 0, 0, 0, 5, 0, 0, ADD, 0);
        cyc(0, SW, 0, 0, 1, 5, 0, 0, ADD, 0);
        // R-type sub, slt, and an undefined funct
        cyc(0, RT, 6'b100010, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, RT, 6'b100010, 0, 1, 1, 0, 0, ADD, 0);
        cyc(0, RT, 6'b100010, 0, 1, 6, 0, 0, SUB, 0);
        cyc(0, RT, 6'b100010, 0, 1, 7, 0, 0, ADD, 0);
        cyc(0, RT, 6'b101010, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, RT, 6'b101010, 0, 1, 1, 0, 0, ADD, 0);
        cyc(0, RT, 6'b101010, 0, 1, 6, 0, 0, 3'b111, 0);
        cyc(0, RT, 6'b101010, 0, 1, 7, 0, 0, ADD, 0);
        cyc(0, RT, 6'b111111, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, RT, 6'b111111, 0, 1, 1, 0, 0, ADD, 0);
        cyc(0, RT, 6'b111111, 0, 1, 6, 0, 0, 3'b000, 0);
        cyc(0, RT, 6'b111111, 0, 1, 7, 0, 0, ADD, 0);
        // beq taken / not taken, bne taken / not taken
        cyc(0, BEQ, 0, 1, 1, 0, 1, 1, ADD, 0);
        cyc(0, BEQ, 0, 1, 1, 1, 0, 0, ADD, 0);
        cyc(0, BEQ, 0, 1, 1, 8, 1, 0, SUB, 0);
        cyc(0, BEQ, 0, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, BEQ, 0, 0, 1, 1, 0, 0, ADD, 0);
        cyc(0, BEQ, 0, 0, 1, 8, 0, 0, SUB, 0);
        cyc(0, BNE, 0, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, BNE, 0, 0, 1, 1, 0, 0, ADD, 0);
        cyc(0, BNE, 0, 0, 1, 12, 1, 0, SUB, 0);
        cyc(0, BNE, 0, 1, 1, 0, 1, 1, ADD, 0);
        cyc(0, BNE, 0, 1, 1, 1, 0, 0, ADD, 0);
        cyc(0, BNE, 0, 1, 1, 12, 0, 0, SUB, 0);
        // addi, ori
        cyc(0, ADDI, 0, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, ADDI, 0, 0, 1, 1, 0, 0, ADD, 0);
        cyc(0, ADDI, 0, 0, 1, 9, 0, 0, ADD, 0);
        cyc(0, ADDI, 0, 0, 1, 10, 0, 0, ADD, 0);
        cyc(0, ORI, 0, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, ORI, 0, 0, 1, 1, 0, 0, ADD, 0);
        cyc(0, ORI, 0, 0, 1, 13, 0, 0, OR, 0);
        cyc(0, ORI, 0, 0, 1, 10, 0, 0, ADD, 0);
        // j
        cyc(0, J, 0, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, J, 0, 0, 1, 1, 0, 0, ADD, 0);
        cyc(0, J, 0, 0, 1, 11, 1, 0, ADD, 0);
        // Fetch wait, then illegal opcode back to FETCH
        cyc(0, BAD, 0, 0, 0, 0, 0, 0, ADD, 0);
        cyc(0, BAD, 0, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, BAD, 0, 0, 1, 1, 0, 0, ADD, 1);
        // sw aborted by reset while memwrite would be high
        cyc(0, SW, 0, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, SW, 0, 0, 1, 1, 0, 0, ADD, 0);
        cyc(0, SW, 0, 0, 1, 2, 0, 0, ADD, 0);
        cyc(0, SW, 0, 0, 0, 5, 0, 0, ADD, 0);
        cyc(1, SW, 0, 0, 0, 5, 0, 0, ADD, 0);
        cyc(0, SW, 0, 0, 0, 0, 0, 0, ADD, 0);
        cyc(0, SW, 0, 0, 1, 0, 1, 1, ADD, 0);
        cyc(0, SW, 0, 0, 1, 1, 0, 0, ADD, 0);
        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
